// File: rtl/pulse_handshake_if.sv
// Handshake bundle between the toggle pulse transmitter and its environment.
// master = transmitter side, slave = event source / receiver side.
interface pulse_handshake_if #(
   parameter int CNT_W = 4
);
   logic             src_pulse;
   logic             ovf_clr;
   logic             dst_ack;
   logic             src_req;
   logic             src_busy;
   logic [CNT_W-1:0] pend_cnt;
   logic             src_full;
   logic             src_ovf;

   modport master (
      input  src_pulse, ovf_clr, dst_ack,
      output src_req, src_busy, pend_cnt, src_full, src_ovf
   );

   modport slave (
      output src_pulse, ovf_clr, dst_ack,
      input  src_req, src_busy, pend_cnt, src_full, src_ovf
   );
endinterface

// File: rtl/pulse_handshake_tx.sv
// Source side of a lossless toggle pulse synchronizer: queues events in a
// saturating counter and sends one toggle per echoed acknowledge.
module pulse_handshake_tx #(
   parameter int CNT_W    = 4,
   parameter int SYNC_STG = 2
) (
   input  logic              src_clk,
   input  logic              src_rst_n,
   pulse_handshake_if.master hs
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SYNC_STG-1:0] ack_pipe;
   logic                ack_sync;
   logic                req_q;
   logic                ovf_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                launch;
   logic                busy;
   logic                full;
   logic                drop;
   logic                aligned;

   // dst_ack is asynchronous; only ack_sync may be used downstream
   always_ff @(posedge src_clk) begin
      if (!src_rst_n) ack_pipe <= '0;
      else            ack_pipe <= {ack_pipe[SYNC_STG-2:0], hs.dst_ack};
   end

   assign ack_sync = ack_pipe[SYNC_STG-1];
   assign aligned  = (ack_sync == req_q);
   assign full     = (cnt_q == CNT_MAX);

   always_ff @(posedge src_clk) begin
      if (!src_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (cnt_q != '0 && aligned) state_nxt = WAIT_ACK;
         WAIT_ACK: if (aligned)                state_nxt = IDLE;
         default:                              state_nxt = IDLE;
      endcase
   end

   // A mismatched ack after a one-sided reset blocks launch until realigned
   always_comb begin
      launch = 1'b0;
      busy   = 1'b0;
      case (state)
         IDLE:     launch = (cnt_q != '0) && aligned;
         WAIT_ACK: busy   = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge src_clk) begin
      if (!src_rst_n)  req_q <= 1'b0;
      else if (launch) req_q <= ~req_q;
   end

   // Pulse coinciding with launch nets to zero, even when full
   assign drop = hs.src_pulse && full && !launch;

   always_ff @(posedge src_clk) begin
      if (!src_rst_n) begin
         cnt_q <= '0;
      end else if (hs.src_pulse && !launch && !full) begin
         cnt_q <= cnt_q + CNT_ONE;
      end else if (launch && !hs.src_pulse) begin
         cnt_q <= cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge src_clk) begin
      if (!src_rst_n)      ovf_q <= 1'b0;
      else if (drop)       ovf_q <= 1'b1;
      else if (hs.ovf_clr) ovf_q <= 1'b0;
   end

   assign hs.src_req  = req_q;
   assign hs.src_busy = busy;
   assign hs.pend_cnt = cnt_q;
   assign hs.src_full = full;
   assign hs.src_ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Randomized and directed bench for pulse_handshake_tx against an event-level
// model; the remote receiver is emulated as a variable-delay echo of src_req.
module tb_pulse_handshake_tx;

   localparam int CNT_W    = 2;
   localparam int SYNC_STG = 2;
   localparam int MAXP     = (1 << CNT_W) - 1;

   logic src_clk = 1'b0;
   logic src_rst_n;

   pulse_handshake_if #(.CNT_W(CNT_W)) hs ();

   pulse_handshake_tx #(.CNT_W(CNT_W), .SYNC_STG(SYNC_STG)) dut (
      .src_clk   (src_clk),
      .src_rst_n (src_rst_n),
      .hs        (hs.master)
   );

   always #5 src_clk = ~src_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   int m_pend;
   bit m_req, m_busy, m_ovf;
   bit m_ack_q[$];

   // remote emulation: echo delay in cycles, or a held level
   int ack_dly  = 1;
   bit ack_hold = 1'b1;
   bit ack_val  = 1'b0;
   bit req_hist[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
      end
   endtask

   function automatic bit m_launch_next();
      return !m_busy && m_pend != 0 && m_ack_q[0] == m_req;
   endfunction

   task automatic model_edge();
      bit as, launch;
      as = m_ack_q[0];
      if (!src_rst_n) begin
         m_req = 0; m_busy = 0; m_pend = 0; m_ovf = 0;
         m_ack_q.delete();
         for (int i = 0; i < SYNC_STG; i++) m_ack_q.push_back(1'b0);
         return;
      end
      void'(m_ack_q.pop_front());
      m_ack_q.push_back(hs.dst_ack);
      launch = !m_busy && m_pend != 0 && as == m_req;
      if (hs.src_pulse && !launch && m_pend == MAXP) m_ovf = 1;
      else if (hs.ovf_clr)                         m_ovf = 0;
      if (hs.src_pulse && !launch) m_pend = (m_pend < MAXP) ? m_pend + 1 : m_pend;
      else if (launch && !hs.src_pulse) m_pend--;
      if (launch) begin
         m_req  = !m_req;
         m_busy = 1;
      end else if (m_busy && as == m_req) begin
         m_busy = 0;
      end
   endtask

   task automatic step();
      @(posedge src_clk);
      model_edge();
      @(negedge src_clk);
      chk("req",  hs.src_req,  m_req);
      chk("busy", hs.src_busy, m_busy);
      chk("pend", hs.pend_cnt, m_pend);
      chk("full", hs.src_full, m_pend == MAXP);
      chk("ovf",  hs.src_ovf,  m_ovf);
      hs.dst_ack = ack_hold ? ack_val : req_hist[ack_dly-1];
      req_hist.push_front(hs.src_req);
      void'(req_hist.pop_back());
   endtask

   task automatic do_reset();
      hs.src_pulse = 0; hs.ovf_clr = 0;
      ack_hold = 1; ack_val = 0;
      src_rst_n = 0;
      repeat (2) step();
      src_rst_n = 1;
      repeat (5) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit prev;
      int edges[$];
      int pmax, tog;

      for (int i = 0; i < 8; i++) req_hist.push_back(1'b0);
      for (int i = 0; i < SYNC_STG; i++) m_ack_q.push_back(1'b0);
      hs.src_pulse = 1; hs.ovf_clr = 0; hs.dst_ack = 1;
      ack_hold = 1; ack_val = 1;
      src_rst_n = 0;
      @(negedge src_clk);

      // reset with pulse and ack asserted
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_req", hs.src_req, 0);
         chk("rst_busy", hs.src_busy, 0);
         chk("rst_pend", hs.pend_cnt, 0);
         chk("rst_full", hs.src_full, 0);
         chk("rst_ovf", hs.src_ovf, 0);
      end
      hs.src_pulse = 0; ack_val = 0; hs.dst_ack = 0;
      src_rst_n = 1;
      step();
      chk("rel_req", hs.src_req, 0);
      chk("rel_pend", hs.pend_cnt, 0);
      chk("rel_busy", hs.src_busy, 0);
      repeat (4) step();

      // single event through a 1-flop loopback
      ack_hold = 0; ack_dly = 1;
      hs.src_pulse = 1; step();
      chk("single_pend0", hs.pend_cnt, 1);
      hs.src_pulse = 0; step();
      chk("single_req1", hs.src_req, 1);
      chk("single_busy1", hs.src_busy, 1);
      repeat (3) step();
      chk("single_busy4", hs.src_busy, 1);
      step();
      chk("single_busy5", hs.src_busy, 0);
      chk("single_pend5", hs.pend_cnt, 0);
      repeat (3) step();

      // three back-to-back pulses
      prev = hs.src_req; pmax = 0;
      for (int e = 0; e <= 16; e++) begin
         hs.src_pulse = (e < 3);
         step();
         if (hs.src_req != prev) edges.push_back(e);
         prev = hs.src_req;
         if (int'(hs.pend_cnt) > pmax) pmax = hs.pend_cnt;
         if (e == 14) chk("burst_busy14", hs.src_busy, 1);
         if (e == 15) chk("burst_busy15", hs.src_busy, 0);
      end
      chk("burst_nlaunch", edges.size(), 3);
      if (edges.size() == 3) begin
         chk("burst_l0", edges[0], 1);
         chk("burst_l1", edges[1], 6);
         chk("burst_l2", edges[2], 11);
      end
      chk("burst_pmax", pmax, 2);
      chk("burst_ovf", hs.src_ovf, 0);

      // overflow with the ack held low
      do_reset();
      edges.delete(); prev = hs.src_req;
      for (int e = 0; e <= 6; e++) begin
         hs.src_pulse = (e <= 4);
         hs.ovf_clr   = (e == 6);
         step();
         if (hs.src_req != prev) edges.push_back(e);
         prev = hs.src_req;
         if (e == 3) begin
            chk("ovf_pend3", hs.pend_cnt, 3);
            chk("ovf_full3", hs.src_full, 1);
            chk("ovf_flag3", hs.src_ovf, 0);
         end
         if (e == 4) chk("ovf_flag4", hs.src_ovf, 1);
         if (e == 5) chk("ovf_flag5", hs.src_ovf, 1);
      end
      hs.ovf_clr = 0;
      chk("ovf_clr", hs.src_ovf, 0);
      chk("ovf_pend6", hs.pend_cnt, 3);
      chk("ovf_nlaunch", edges.size(), 1);
      if (edges.size() == 1) chk("ovf_ledge", edges[0], 1);

      // pulse on the launch edge while full
      ack_hold = 0; ack_dly = 1;
      begin
         int n = 0;
         while (!m_launch_next() && n < 20) begin
            step();
            n++;
         end
         chk("fl_reach", n < 20, 1);
      end
      hs.src_pulse = 1; step(); hs.src_pulse = 0;
      chk("fl_pend", hs.pend_cnt, 3);
      chk("fl_ovf", hs.src_ovf, 0);
      chk("fl_busy", hs.src_busy, 1);
      repeat (4) step();

      // one-sided reset while the remote holds ack high
      do_reset();
      ack_hold = 0; ack_dly = 1;
      hs.src_pulse = 1; step();
      hs.src_pulse = 0; step();
      chk("mr_busy", hs.src_busy, 1);
      ack_hold = 1; ack_val = 1;
      src_rst_n = 0; repeat (2) step();
      src_rst_n = 1; repeat (3) step();
      hs.src_pulse = 1; repeat (2) step();
      hs.src_pulse = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("mr_req", hs.src_req, 0);
         chk("mr_busy_i", hs.src_busy, 0);
      end
      chk("mr_pend", hs.pend_cnt, 2);
      ack_hold = 0; ack_dly = 1;
      tog = 0; prev = hs.src_req;
      for (int i = 0; i < 40; i++) begin
         step();
         if (hs.src_req != prev) tog++;
         prev = hs.src_req;
      end
      chk("mr_tog", tog, 2);
      chk("mr_pend_end", hs.pend_cnt, 0);

      // randomized traffic, echo delays, stuck acks and stray resets
      for (int seg = 0; seg < 20; seg++) begin
         int r, p;
         r = $urandom_range(0, 9);
         if (r < 7) begin
            ack_hold = 0; ack_dly = $urandom_range(1, 4);
         end else begin
            ack_hold = 1; ack_val = (r == 9);
         end
         p = $urandom_range(5, 90);
         for (int c = 0; c < 150; c++) begin
            hs.src_pulse = ($urandom_range(0, 99) < p);
            hs.ovf_clr   = ($urandom_range(0, 31) == 0);
            src_rst_n    = ($urandom_range(0, 399) != 0);
            step();
         end
      end
      src_rst_n = 1; hs.src_pulse = 0; hs.ovf_clr = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
